q_sweep_sequencer: RTL and testbench
====================================

Name: q_sweep_sequencer

Overview:
Controller that sequences the Q-measurement front-end to find the instability point of the resonator bias. It sweeps the i_ref DAC code downward from full scale, waits for the analog path to settle, triggers a measurement and waits for its ready handshake. It evaluates the Q jump between consecutive steps and, when instability is found, backs off by a fixed margin and publishes the safe upper bound for the Q control loop.

Parameters:
BUS_WIDTH, 10, width of DAC code and Q measurement bus
DELTA_Q_INSTB, 300, Q increase between consecutive steps that counts as instability (strictly greater)
I_REF_STEP, 50, DAC code decrement per sweep step
BACKOFF_STEPS, 2, steps added back above the unstable code to form the limit
SETTLE_CYCLES, 16, clk cycles to wait after each new i_ref before measuring (>=1)
MEAS_TIMEOUT, 1023, max clk cycles to wait for meas_ready

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a sweep; ignored while busy
meas_ready  input  1  measurement complete; q_measured valid in the same cycle
q_measured  input  BUS_WIDTH  measured Q value, unsigned
meas_start  output  1  one-cycle pulse requesting a measurement
i_ref  output  BUS_WIDTH  DAC code driven to the bias generator
i_ref_limit  output  BUS_WIDTH  result: upper bound for Q control
busy  output  1  high from the cycle after start until completion
done  output  1  level; high after completion until the next accepted start
found  output  1  valid while done; 1 = instability detected
timeout_err  output  1  valid while done; 1 = meas_ready timed out

Behaviour:
- Reset (sync, clk and rst sampled high): state IDLE; i_ref = 2^BUS_WIDTH-1; i_ref_limit = 2^BUS_WIDTH-1; meas_start, busy, done, found, timeout_err = 0; internal last_q = 0; first_sample flag set. Reset mid-sweep aborts immediately with the same values.
- States: IDLE, SETTLE, MEAS, WAIT, EVAL, DONE.
- IDLE: if start, load i_ref = max, set first_sample, clear done/found/timeout_err, go to SETTLE; busy rises the next cycle.
- SETTLE: count SETTLE_CYCLES cycles, then go to MEAS.
- MEAS: single cycle; meas_start = 1; go to WAIT; clear the timeout counter.
- WAIT: meas_ready is sampled only in this state, so a ready in the MEAS cycle is ignored. On meas_ready, capture q_measured into cur_q and go to EVAL. If the counter reaches MEAS_TIMEOUT first: timeout_err = 1, found = 0, i_ref_limit = max, go to DONE.
- EVAL (1 cycle):
  - If first_sample, no comparison is made; clear the flag.
  - Else if cur_q > last_q and (cur_q - last_q) > DELTA_Q_INSTB: found = 1; i_ref_limit = i_ref + BACKOFF_STEPS*I_REF_STEP, computed at BUS_WIDTH+2 bits and saturated to max; go to DONE.
  - If not found, last_q = cur_q. If i_ref < I_REF_STEP, the sweep is exhausted: found = 0, i_ref_limit = max, go to DONE. Otherwise i_ref -= I_REF_STEP and go to SETTLE.
  - Decreasing Q never triggers, and unsigned wrap is never used.
- DONE: busy = 0, done = 1; i_ref is driven to i_ref_limit; go to IDLE. The result flags hold until the next accepted start.
- start while busy is ignored. start together with rst: reset wins.
- Latency per step: SETTLE_CYCLES + 2 + measurement time + 1 cycles.

Optional Feature:
Macro Q_SWEEP_AVERAGE_EN.
- With the macro: each step issues 4 measurements (MEAS/WAIT repeated), accumulated in BUS_WIDTH+2 bits. cur_q = sum >> 2, truncated. Each measurement has its own timeout.
- Without the macro: one measurement per step, as described above.

Decomposition:
- Package q_frontend_pkg: state enum, I_REF_MAX = 2^BUS_WIDTH-1 constant, saturating-add function.
- One natural sub-module: cycle_timer, a loadable down-counter with an expired flag, reused for SETTLE and the WAIT timeout.

Test Plan:
- Instability found: defaults; model returns q=100 for i_ref>=773 and q=500 at 723. Sweep visits 1023,973,…,723 -> found=1, i_ref_limit=823, i_ref=823 in DONE, 7 meas_start pulses.
- No instability: q constant at 200 -> sweep runs to code 23 (21 measurements) -> found=0, i_ref_limit=1023, timeout_err=0.
- Backoff saturation: q=100 at 1023, q=450 at 973 -> found=1, i_ref_limit=1023 (1073 saturated). Separate case: q=900 at 1023 only -> no trigger.
- Timeout: meas_ready never asserted -> timeout_err=1 exactly 1023 cycles after the first meas_start; found=0; i_ref_limit=1023.
- Reset mid-sweep: assert rst during WAIT at code 873 -> next cycle IDLE, i_ref=1023, busy=0, done=0. A following start restarts from 1023; start pulses while busy do not restart.
- Threshold edge: Δq exactly 300 -> no trigger; Δq = 301 -> trigger. With Q_SWEEP_AVERAGE_EN, samples 100,101,102,103 give cur_q = 101.

Source files
------------

// File: rtl/q_frontend_pkg.sv
// q_frontend_pkg: shared types and helpers for the Q-measurement front-end sequencer
package q_frontend_pkg;
    typedef enum logic [2:0] {IDLE, SETTLE, MEAS, WAIT, EVAL, DONE} state_t;
    localparam int BUS_WIDTH_DEF = 10;
    localparam int I_REF_MAX = 2**BUS_WIDTH_DEF - 1;
    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned max);
        return (a + b > max) ? max : a + b;
    endfunction
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter; expired while the count rests at zero
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else cnt <= load ? load_val : (cnt != '0 ? cnt - W'(1) : cnt);
    end
    assign expired = cnt == '0;
endmodule

// File: rtl/q_sweep_sequencer.sv
// q_sweep_sequencer: sweeps i_ref down, measures Q per step and publishes a backed-off limit.
// Q_SWEEP_AVERAGE_EN: average four measurements per step instead of one.
module q_sweep_sequencer
    import q_frontend_pkg::*;
#(
    parameter int BUS_WIDTH     = BUS_WIDTH_DEF,
    parameter int DELTA_Q_INSTB = 300,
    parameter int I_REF_STEP    = 50,
    parameter int BACKOFF_STEPS = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int MEAS_TIMEOUT  = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 meas_ready,
    input  logic [BUS_WIDTH-1:0] q_measured,
    output logic                 meas_start,
    output logic [BUS_WIDTH-1:0] i_ref,
    output logic [BUS_WIDTH-1:0] i_ref_limit,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic                 timeout_err
);
    localparam int TW = $clog2(SETTLE_CYCLES + MEAS_TIMEOUT + 1);
    localparam logic [BUS_WIDTH-1:0] MAX  = '1;
    localparam logic [BUS_WIDTH-1:0] STEP = BUS_WIDTH'(I_REF_STEP);
    localparam logic [BUS_WIDTH-1:0] DQ   = BUS_WIDTH'(DELTA_Q_INSTB);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    // timeout_err shows up exactly MEAS_TIMEOUT cycles after the meas_start cycle
    localparam logic [TW-1:0] WAIT_LOAD   = TW'(MEAS_TIMEOUT - 2);
    state_t state, state_n;
    logic [BUS_WIDTH-1:0] i_ref_n, limit_n, last_q, last_q_n, cur_q, cur_q_n, fin_limit, backoff;
    logic busy_n, done_n, found_n, tmo_n, first, first_n, fin, tmr_load, expired;
    logic [TW-1:0] tmr_val;
`ifdef Q_SWEEP_AVERAGE_EN
    logic [BUS_WIDTH+1:0] sum, sum_n, acc;
    logic [1:0] cnt, cnt_n;
`endif
    cycle_timer #(.W(TW)) u_timer (
        .clk(clk), .rst(rst), .load(tmr_load), .load_val(tmr_val), .expired(expired)
    );
    assign meas_start = state == MEAS;
    assign backoff = BUS_WIDTH'(sat_add(int'(i_ref), BACKOFF_STEPS * I_REF_STEP, 2**BUS_WIDTH - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i_ref <= MAX;
            i_ref_limit <= MAX;
            busy <= 1'b0;
            done <= 1'b0;
            found <= 1'b0;
            timeout_err <= 1'b0;
            last_q <= '0;
            cur_q <= '0;
            first <= 1'b1;
`ifdef Q_SWEEP_AVERAGE_EN
            sum <= '0;
            cnt <= '0;
`endif
        end else begin
            state <= state_n;
            i_ref <= i_ref_n;
            i_ref_limit <= limit_n;
            busy <= busy_n;
            done <= done_n;
            found <= found_n;
            timeout_err <= tmo_n;
            last_q <= last_q_n;
            cur_q <= cur_q_n;
            first <= first_n;
`ifdef Q_SWEEP_AVERAGE_EN
            sum <= sum_n;
            cnt <= cnt_n;
`endif
        end
    end
    always_comb begin
        state_n = state;
        i_ref_n = i_ref;
        limit_n = i_ref_limit;
        busy_n = busy;
        done_n = done;
        found_n = found;
        tmo_n = timeout_err;
        last_q_n = last_q;
        cur_q_n = cur_q;
        first_n = first;
        tmr_load = 1'b0;
        tmr_val = SETTLE_LOAD;
        fin = 1'b0;
        fin_limit = MAX;
`ifdef Q_SWEEP_AVERAGE_EN
        acc = sum + {2'b00, q_measured};
        sum_n = sum;
        cnt_n = cnt;
`endif
        case (state)
            IDLE: if (start) begin
                state_n = SETTLE;
                i_ref_n = MAX;
                first_n = 1'b1;
                busy_n = 1'b1;
                done_n = 1'b0;
                found_n = 1'b0;
                tmo_n = 1'b0;
                tmr_load = 1'b1;
`ifdef Q_SWEEP_AVERAGE_EN
                sum_n = '0;
                cnt_n = '0;
`endif
            end
            SETTLE: state_n = expired ? MEAS : SETTLE;
            MEAS: begin
                state_n = WAIT;
                tmr_load = 1'b1;
                tmr_val = WAIT_LOAD;
            end
            WAIT: if (meas_ready) begin
`ifdef Q_SWEEP_AVERAGE_EN
                sum_n = cnt == 2'd3 ? '0 : acc;
                cnt_n = cnt + 2'd1;
                cur_q_n = acc[BUS_WIDTH+1:2];
                state_n = cnt == 2'd3 ? EVAL : MEAS;
`else
                cur_q_n = q_measured;
                state_n = EVAL;
`endif
            end else if (expired) begin
                fin = 1'b1;
                tmo_n = 1'b1;
            end
            EVAL: begin
                first_n = 1'b0;
                if (!first && cur_q > last_q && cur_q - last_q > DQ) begin
                    fin = 1'b1;
                    found_n = 1'b1;
                    fin_limit = backoff;
                end else begin
                    last_q_n = cur_q;
                    if (i_ref < STEP) fin = 1'b1;
                    else begin
                        i_ref_n = i_ref - STEP;
                        tmr_load = 1'b1;
                        state_n = SETTLE;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (fin) begin
            state_n = DONE;
            busy_n = 1'b0;
            done_n = 1'b1;
            limit_n = fin_limit;
            i_ref_n = fin_limit;
        end
    end
endmodule

// File: tb/tb_q_sweep_sequencer.sv
// tb_q_sweep_sequencer: directed and random Q profiles checked against a sweep-level reference model
module tb_q_sweep_sequencer;
    import q_frontend_pkg::*;
`ifdef Q_SWEEP_AVERAGE_EN
    localparam int NAVG = 4;
`else
    localparam int NAVG = 1;
`endif
    localparam int W = 10;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, meas_ready = 1'b0;
    logic [W-1:0] q_measured = '0;
    logic meas_start, busy, done, found, timeout_err;
    logic [W-1:0] i_ref, i_ref_limit;
    int checks = 0, errors = 0, n_meas = 0;
    bit resp_on = 1'b1;
    int q_prof [0:1023];

    q_sweep_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .meas_ready(meas_ready), .q_measured(q_measured),
        .meas_start(meas_start), .i_ref(i_ref), .i_ref_limit(i_ref_limit), .busy(busy),
        .done(done), .found(found), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int from, input int hi, input int lo);
        for (int c = 0; c < 1024; c++) q_prof[c] = c >= from ? hi : lo;
    endtask

    // Sweep-level reference: walk the visited codes, average samples, apply the jump rule
    function automatic void model(output bit f, output int lim, output int nm);
        int code, last, cur;
        bit first;
        code = 1023; last = 0; first = 1'b1;
        f = 1'b0; lim = 1023; nm = 0;
        for (int s = 0; s < 21; s++) begin
            cur = 0;
            for (int k = 0; k < NAVG; k++) cur += q_prof[code] + k;
            cur /= NAVG;
            nm += NAVG;
            if (!first && cur - last > 300) begin
                f = 1'b1;
                lim = code + 100 > 1023 ? 1023 : code + 100;
                return;
            end
            first = 1'b0;
            last = cur;
            if (code < 50) return;
            code -= 50;
        end
    endfunction

    // Front-end responder: answers each meas_start after 1..4 cycles from the current profile
    initial begin
        forever begin
            @(negedge clk);
            meas_ready = 1'b0;
            if (meas_start === 1'b1 && resp_on) begin
                n_meas++;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                q_measured = W'(q_prof[i_ref] + (n_meas - 1) % NAVG);
                meas_ready = 1'b1;
            end
        end
    end

    task automatic run_sweep(input string tag, input bit poke);
        bit ef;
        int el, enm, cyc;
        model(ef, el, enm);
        n_meas = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_done_clr"}, done, 0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = (poke && cyc == 30) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_found"}, found, ef);
        check({tag, "_limit"}, i_ref_limit, el);
        check({tag, "_i_ref"}, i_ref, el);
        check({tag, "_tmo"}, timeout_err, 0);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_n_meas"}, n_meas, enm);
        @(negedge clk);
        check({tag, "_done_hold"}, done, 1);
        check({tag, "_found_hold"}, found, ef);
    endtask

    initial begin
        int v, cyc;
        repeat (3) @(negedge clk);
        check("rst_i_ref", i_ref, I_REF_MAX);
        check("rst_limit", i_ref_limit, I_REF_MAX);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_meas_start", meas_start, 0);
        rst = 1'b0;
        @(negedge clk);

        fill(773, 100, 500);
        run_sweep("instab", 1'b0);
        check("instab_spec_limit", i_ref_limit, 823);
        check("instab_spec_meas", n_meas, 7 * NAVG);

        fill(0, 200, 200);
        run_sweep("flat", 1'b0);
        check("flat_spec_meas", n_meas, 21 * NAVG);

        fill(1000, 100, 450);
        run_sweep("sat", 1'b0);
        check("sat_spec_limit", i_ref_limit, 1023);

        fill(1000, 900, 0);
        run_sweep("drop", 1'b0);

        fill(850, 100, 400);
        run_sweep("delta300", 1'b0);
        fill(850, 100, 401);
        run_sweep("delta301", 1'b0);
        check("delta301_spec_limit", i_ref_limit, 923);

        for (int t = 0; t < 6; t++) begin
            fill(0, 0, 0);
            v = int'($urandom_range(0, 300));
            for (int c = 1023; c >= 0; c -= 50) begin
                q_prof[c] = v;
                v += ($urandom_range(0, 5) == 0) ? int'($urandom_range(280, 340)) : int'($urandom_range(0, 40));
                v -= int'($urandom_range(0, 40));
                v = v < 0 ? 0 : (v > 1000 ? 1000 : v);
            end
            run_sweep($sformatf("rand%0d", t), 1'b0);
        end

        resp_on = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (meas_start !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        check("tmo_first_meas", meas_start, 1);
        cyc = 0;
        while (timeout_err !== 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
        check("tmo_latency", cyc, 1023);
        check("tmo_done", done, 1);
        check("tmo_found", found, 0);
        check("tmo_limit", i_ref_limit, 1023);
        check("tmo_i_ref", i_ref, 1023);
        resp_on = 1'b1;
        @(negedge clk);

        fill(0, 200, 200);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(meas_start === 1'b1 && i_ref === 10'd873) && cyc < 1000) begin @(negedge clk); cyc++; end
        check("mid_reach_873", i_ref, 873);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_i_ref", i_ref, 1023);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_meas_start", meas_start, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        run_sweep("restart", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
